// File: rtl/pipe_mem_stage.sv
// Memory stage: EXE/MEM pipeline register plus a req/ack data-memory handshake with timeout abort.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses are suppressed and flagged on align_err.

module pipe_mem_stage #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [31:0] ealu,
    input  logic [31:0] eb,
    input  logic [4:0]  ern,
    output logic        mwreg,
    output logic        mm2reg,
    output logic [4:0]  mrn,
    output logic [31:0] malu,
    output logic [31:0] mmo,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        bus_err,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        align_err,
`endif
    output logic [31:0] stall_cnt
);
    localparam logic [0:0]    IDLE = 1'b0;
    localparam logic [0:0]    WAIT = 1'b1;
    localparam logic [CW-1:0] TMO  = CW'(TIMEOUT);

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
    } exmem_t;

    exmem_t        m_q;
    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          memop;
    logic          misalign;
    logic          abort;

    // EXE/MEM register freezes while the access is outstanding.
    always_ff @(posedge clock) begin
        if (reset) begin
            m_q <= '0;
        end else if (!mem_stall) begin
            m_q.wreg  <= ewreg;
            m_q.m2reg <= em2reg;
            m_q.wmem  <= ewmem;
            m_q.alu   <= ealu;
            m_q.b     <= eb;
            m_q.rn    <= ern;
        end
    end

    assign memop = m_q.m2reg | m_q.wmem;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign  = memop & (m_q.alu[1:0] != 2'b00);
    assign align_err = misalign & ~reset;
`else
    assign misalign  = 1'b0;
`endif

    // Ack in the last allowed cycle still counts as a normal completion.
    assign abort     = (state == WAIT) & ~dmem_ack & (cnt == TMO) & ~reset;
    assign dmem_req  = memop & ~reset & ~abort & ~misalign;
    assign mem_stall = dmem_req & ~dmem_ack;
    assign bus_err   = abort;

    assign mwreg      = m_q.wreg & ~abort & ~(misalign & m_q.m2reg);
    assign mm2reg     = m_q.m2reg;
    assign mrn        = m_q.rn;
    assign malu       = m_q.alu;
    assign mmo        = dmem_rdata;
    assign dmem_we    = m_q.wmem;
    assign dmem_addr  = m_q.alu;
    assign dmem_wdata = m_q.b;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dmem_req && !dmem_ack) begin
                        state <= WAIT;
                        cnt   <= CW'(1);
                    end
                end
                WAIT: begin
                    if (dmem_ack || cnt >= TMO) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset)          stall_cnt <= '0;
        else if (mem_stall) stall_cnt <= stall_cnt + 32'd1;
    end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Bench for pipe_mem_stage (TIMEOUT=4): vector table, corner-case sequences, randomized run vs. model.
// Define MEM_ALIGN_CHECK_EN to also exercise the alignment check.

module tb_pipe_mem_stage;
    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ewreg = 1'b0, em2reg = 1'b0, ewmem = 1'b0;
    logic [31:0] ealu = '0, eb = '0;
    logic [4:0]  ern = '0;
    logic        mwreg, mm2reg, mem_stall, dmem_req, dmem_we, bus_err;
    logic [4:0]  mrn;
    logic [31:0] malu, mmo, dmem_addr, dmem_wdata, stall_cnt;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int checks = 0;
    int errors = 0;

    pipe_mem_stage #(.TIMEOUT(TO), .CW(8)) dut (
        .clock(clock), .reset(reset),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .ealu(ealu), .eb(eb), .ern(ern),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .malu(malu), .mmo(mmo),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .bus_err(bus_err),
`ifdef MEM_ALIGN_CHECK_EN
        .align_err(align_err),
`endif
        .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic w, input logic m, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        ewreg = w; em2reg = m; ewmem = s; ealu = a; eb = b; ern = r;
    endtask

    task automatic bubble();
        drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; bubble(); dmem_ack = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        #1;
        chk({tag, "_mwreg"}, mwreg, 0);
        chk({tag, "_mm2reg"}, mm2reg, 0);
        chk({tag, "_mrn"}, mrn, 0);
        chk({tag, "_malu"}, malu, 0);
        chk({tag, "_req"}, dmem_req, 0);
        chk({tag, "_stall"}, mem_stall, 0);
        chk({tag, "_buserr"}, bus_err, 0);
        chk({tag, "_stallcnt"}, stall_cnt, 0);
    endtask

    typedef struct {
        logic        wreg, m2reg, wmem;
        logic [31:0] alu, b;
        logic [4:0]  rn;
        logic        ack;
        logic [31:0] rdata;
        logic        x_mwreg, x_mm2reg, x_req, x_we, x_stall;
        logic [4:0]  x_rn;
        logic [31:0] x_alu, x_wdata, x_mmo;
    } vec_t;

    typedef struct {
        logic        wreg, m2reg, wmem;
        logic [31:0] alu, b;
        logic [4:0]  rn;
        int          lat;
    } inst_t;

    function automatic inst_t rand_inst();
        inst_t t;
        int    kind;
        kind    = $urandom_range(0, 3);
        t.wreg  = (kind == 1) || (kind == 2);
        t.m2reg = (kind == 2);
        t.wmem  = (kind == 3);
        t.alu   = $urandom;
        if ($urandom_range(0, 3) != 0) t.alu[1:0] = 2'b00;
        t.b     = $urandom;
        t.rn    = 5'($urandom_range(0, 31));
        t.lat   = $urandom_range(0, TO + 2);
        return t;
    endfunction

    vec_t  vecs[5];
    inst_t mi, ex;
    int    k, scnt;
    logic  memop, misal, abrt, ereq, estall;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 5'd0, 1'b1, 32'h0,
                    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_0200, 32'hA5A5_A5A5, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd12, 1'b1, 32'h1122_3344,
                    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_0300, 32'h0, 32'h1122_3344};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h9999_0000, 32'h1, 5'd0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h9999_0000, 32'h1, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 5'd31, 1'b0, 32'hCAFE_F00D,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 32'hFFFF_FFFC, 32'h0, 32'hCAFE_F00D};

        do_reset();
        chk_reset_state("rst0");

        // Single-instruction vectors, each followed by a bubble cycle.
        foreach (vecs[i]) begin
            @(negedge clock);
            drv(vecs[i].wreg, vecs[i].m2reg, vecs[i].wmem, vecs[i].alu, vecs[i].b, vecs[i].rn);
            dmem_ack = 1'b0;
            @(negedge clock);
            bubble();
            dmem_ack = vecs[i].ack; dmem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_mwreg", i), mwreg, vecs[i].x_mwreg);
            chk($sformatf("v%0d_mm2reg", i), mm2reg, vecs[i].x_mm2reg);
            chk($sformatf("v%0d_req", i), dmem_req, vecs[i].x_req);
            chk($sformatf("v%0d_we", i), dmem_we, vecs[i].x_we);
            chk($sformatf("v%0d_stall", i), mem_stall, vecs[i].x_stall);
            chk($sformatf("v%0d_mrn", i), mrn, vecs[i].x_rn);
            chk($sformatf("v%0d_malu", i), malu, vecs[i].x_alu);
            chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].x_alu);
            chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].x_wdata);
            chk($sformatf("v%0d_mmo", i), mmo, vecs[i].x_mmo);
            @(negedge clock);
            dmem_ack = 1'b0;
            #1;
            chk($sformatf("v%0d_onereq", i), dmem_req, 0);
        end
        chk("vec_stallcnt", stall_cnt, 0);

        // Load with three wait cycles; next instruction must not enter until ack.
        do_reset();
        drv(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd3);
        @(negedge clock);
        drv(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd7);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("ld3_stall%0d", c), mem_stall, 1);
            chk($sformatf("ld3_req%0d", c), dmem_req, 1);
            chk($sformatf("ld3_hold%0d", c), malu, 32'h100);
            @(negedge clock);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld3_ackstall", mem_stall, 0);
        chk("ld3_mmo", mmo, 32'hDEAD_BEEF);
        chk("ld3_mwreg", mwreg, 1);
        chk("ld3_mrn", mrn, 3);
        @(negedge clock);
        dmem_ack = 1'b0; bubble();
        #1;
        chk("ld3_next_malu", malu, 32'h55);
        chk("ld3_next_req", dmem_req, 0);
        chk("ld3_stallcnt", stall_cnt, 3);

        // Load that never gets an ack: TO stall cycles then one abort cycle.
        drv(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd9);
        @(negedge clock);
        drv(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd2);
        for (int c = 0; c < TO; c++) begin
            #1;
            chk($sformatf("to_stall%0d", c), mem_stall, 1);
            chk($sformatf("to_berr%0d", c), bus_err, 0);
            @(negedge clock);
        end
        #1;
        chk("to_buserr", bus_err, 1);
        chk("to_req", dmem_req, 0);
        chk("to_mwreg", mwreg, 0);
        chk("to_stall", mem_stall, 0);
        @(negedge clock);
        bubble();
        #1;
        chk("to_buserr_pulse", bus_err, 0);
        chk("to_next_malu", malu, 32'h77);
        chk("to_next_mwreg", mwreg, 1);

        // Ack arriving in the cycle that would otherwise abort.
        @(negedge clock);
        drv(1'b1, 1'b1, 1'b0, 32'h600, 32'h0, 5'd4);
        @(negedge clock);
        bubble();
        repeat (TO) @(negedge clock);
        dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
        #1;
        chk("edge_buserr", bus_err, 0);
        chk("edge_req", dmem_req, 1);
        chk("edge_stall", mem_stall, 0);
        chk("edge_mwreg", mwreg, 1);
        chk("edge_mmo", mmo, 32'h0BAD_F00D);
        @(negedge clock);
        dmem_ack = 1'b0;

        // Reset while an access is outstanding.
        drv(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 5'd8);
        @(negedge clock);
        bubble();
        #1;
        chk("mrst_stall", mem_stall, 1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mrst_req_drop", dmem_req, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk_reset_state("mrst");

`ifdef MEM_ALIGN_CHECK_EN
        drv(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd4);
        @(negedge clock);
        bubble();
        #1;
        chk("al_err", align_err, 1);
        chk("al_req", dmem_req, 0);
        chk("al_mwreg", mwreg, 0);
        chk("al_stall", mem_stall, 0);
        @(negedge clock);
        #1;
        chk("al_pulse", align_err, 0);
`endif

        // Randomized run against an instruction-level model: an instruction with
        // memory latency lat stalls min(lat, TO) cycles; lat > TO aborts.
        do_reset();
        mi = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0};
        ex = rand_inst();
        k = 0; scnt = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            if (cyc != 0) @(negedge clock);
            drv(ex.wreg, ex.m2reg, ex.wmem, ex.alu, ex.b, ex.rn);
            memop = mi.m2reg | mi.wmem;
`ifdef MEM_ALIGN_CHECK_EN
            misal = memop && (mi.alu[1:0] != 2'b00);
`else
            misal = 1'b0;
`endif
            dmem_ack   = memop && !misal && (k == mi.lat);
            dmem_rdata = $urandom;
            abrt   = memop && !misal && (k == TO) && (mi.lat > TO);
            ereq   = memop && !misal && !abrt;
            estall = ereq && !dmem_ack;
            #1;
            chk("r_req", dmem_req, ereq);
            chk("r_stall", mem_stall, estall);
            chk("r_buserr", bus_err, abrt);
            chk("r_mwreg", mwreg, mi.wreg && !abrt && !(misal && mi.m2reg));
            chk("r_mm2reg", mm2reg, mi.m2reg);
            chk("r_we", dmem_we, mi.wmem);
            chk("r_mrn", mrn, mi.rn);
            chk("r_malu", malu, mi.alu);
            chk("r_addr", dmem_addr, mi.alu);
            chk("r_wdata", dmem_wdata, mi.b);
            chk("r_mmo", mmo, dmem_rdata);
            chk("r_stallcnt", stall_cnt, scnt);
`ifdef MEM_ALIGN_CHECK_EN
            chk("r_alignerr", align_err, misal);
`endif
            @(posedge clock);
            if (estall) begin
                k++;
                scnt++;
            end else begin
                mi = ex;
                k  = 0;
                ex = rand_inst();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
